// File: rtl/sh4a_decode.sv
// sh4a_decode: integer-subset instruction decode stage feeding the integer
// register file. A single-entry output register holds the decoded op. The
// register file read indices are driven so that the registered read data
// always matches the held instruction.
module sh4a_decode #(
  parameter logic [3:0] RESET_OPCODE = 4'd0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        bank_select_i,
  input  logic        flush_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic [15:0] inst_data_i,
  input  logic [31:0] inst_pc_i,
  output logic [4:0]  int_idx_read0_o,
  output logic [4:0]  int_idx_read1_o,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [3:0]  dec_op_o,
  output logic [4:0]  dec_idx_write_o,
  output logic        dec_write_enable_o,
  output logic [31:0] dec_imm_o,
  output logic [31:0] dec_pc_o,
  output logic        dec_illegal_o
);

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_MOV     = 4'd1;
  localparam logic [3:0] OP_MOVI    = 4'd2;
  localparam logic [3:0] OP_ADD     = 4'd3;
  localparam logic [3:0] OP_ADDI    = 4'd4;
  localparam logic [3:0] OP_SUB     = 4'd5;
  localparam logic [3:0] OP_AND     = 4'd6;
  localparam logic [3:0] OP_OR      = 4'd7;
  localparam logic [3:0] OP_XOR     = 4'd8;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  // R0-R7 are banked (bank 1 lives at 16-23); R8-R15 are shared.
  function automatic logic [4:0] phys_idx(input logic [3:0] r, input logic bank);
    phys_idx = r[3] ? {1'b0, r} : {bank, 1'b0, r[2:0]};
  endfunction

  logic        valid_q, valid_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  wr_q, wr_d;
  logic        we_q, we_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic        ill_q, ill_d;
  logic [4:0]  rd0_q, rd0_d;
  logic [4:0]  rd1_q, rd1_d;

  logic [3:0]  dc_op;
  logic [4:0]  dc_rd0, dc_rd1, dc_wr;
  logic        dc_we, dc_ill;
  logic [31:0] dc_imm;
  logic [4:0]  rn, rm;
  logic [31:0] imm_sext;
  logic        accept;

  assign rn       = phys_idx(inst_data_i[11:8], bank_select_i);
  assign rm       = phys_idx(inst_data_i[7:4], bank_select_i);
  assign imm_sext = {{24{inst_data_i[7]}}, inst_data_i[7:0]};

  // Combinational decode of the offered instruction word.
  always_comb begin
    dc_op  = OP_NOP;
    dc_rd0 = 5'd0;
    dc_rd1 = 5'd0;
    dc_wr  = 5'd0;
    dc_we  = 1'b0;
    dc_imm = 32'd0;
    dc_ill = 1'b0;
    if (inst_data_i == 16'h0009) begin
      dc_op = OP_NOP;
    end else if (inst_data_i[15:12] == 4'h6 && inst_data_i[3:0] == 4'h3) begin
      dc_op  = OP_MOV;
      dc_rd0 = rm;
      dc_wr  = rn;
      dc_we  = 1'b1;
    end else if (inst_data_i[15:12] == 4'hE) begin
      dc_op  = OP_MOVI;
      dc_wr  = rn;
      dc_we  = 1'b1;
      dc_imm = imm_sext;
    end else if (inst_data_i[15:12] == 4'h7) begin
      dc_op  = OP_ADDI;
      dc_rd0 = rn;
      dc_wr  = rn;
      dc_we  = 1'b1;
      dc_imm = imm_sext;
    end else if (inst_data_i[15:12] == 4'h3 &&
                 (inst_data_i[3:0] == 4'hC || inst_data_i[3:0] == 4'h8)) begin
      dc_op  = (inst_data_i[3:0] == 4'hC) ? OP_ADD : OP_SUB;
      dc_rd0 = rn;
      dc_rd1 = rm;
      dc_wr  = rn;
      dc_we  = 1'b1;
    end else if (inst_data_i[15:12] == 4'h2 &&
                 (inst_data_i[3:0] == 4'h9 || inst_data_i[3:0] == 4'hB ||
                  inst_data_i[3:0] == 4'hA)) begin
      case (inst_data_i[3:0])
        4'h9:    dc_op = OP_AND;
        4'hB:    dc_op = OP_OR;
        default: dc_op = OP_XOR;
      endcase
      dc_rd0 = rn;
      dc_rd1 = rm;
      dc_wr  = rn;
      dc_we  = 1'b1;
    end else begin
      dc_op  = OP_ILLEGAL;
      dc_ill = 1'b1;
    end
  end

  assign inst_ready_o = !flush_i && (!valid_q || dec_ready_i);
  assign accept       = inst_valid_i && inst_ready_o;

  // Output register next state: flush drops the entry, accept reloads it,
  // a consume without accept only clears valid so the fields stay put.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    wr_d    = wr_q;
    we_d    = we_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    ill_d   = ill_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      op_d    = dc_op;
      wr_d    = dc_wr;
      we_d    = dc_we;
      imm_d   = dc_imm;
      pc_d    = inst_pc_i;
      ill_d   = dc_ill;
      rd0_d   = dc_rd0;
      rd1_d   = dc_rd1;
    end else if (valid_q && dec_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register state with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      op_q    <= RESET_OPCODE;
      wr_q    <= 5'd0;
      we_q    <= 1'b0;
      imm_q   <= 32'd0;
      pc_q    <= 32'd0;
      ill_q   <= 1'b0;
      rd0_q   <= 5'd0;
      rd1_q   <= 5'd0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      wr_q    <= wr_d;
      we_q    <= we_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      ill_q   <= ill_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  // Present the incoming indices only when they will become the held entry,
  // so the registered read data always belongs to the held instruction.
  assign int_idx_read0_o = accept ? dc_rd0 : rd0_q;
  assign int_idx_read1_o = accept ? dc_rd1 : rd1_q;

  assign dec_valid_o        = valid_q;
  assign dec_op_o           = op_q;
  assign dec_idx_write_o    = wr_q;
  assign dec_write_enable_o = we_q;
  assign dec_imm_o          = imm_q;
  assign dec_pc_o           = pc_q;
  assign dec_illegal_o      = ill_q;

endmodule

// File: tb/tb_sh4a_decode.sv
// Testbench for sh4a_decode: table of decode vectors plus hand-written
// stall, flush and streaming/async-reset sequences.
module tb_sh4a_decode;

  logic        clk;
  logic        reset;
  logic        bank_select;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [31:0] inst_pc;
  logic [4:0]  idx_read0;
  logic [4:0]  idx_read1;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_op;
  logic [4:0]  dec_idx_write;
  logic        dec_we;
  logic [31:0] dec_imm;
  logic [31:0] dec_pc;
  logic        dec_illegal;

  int total;
  int passed;

  sh4a_decode #(.RESET_OPCODE(4'd0)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .bank_select_i      (bank_select),
    .flush_i            (flush),
    .inst_valid_i       (inst_valid),
    .inst_ready_o       (inst_ready),
    .inst_data_i        (inst_data),
    .inst_pc_i          (inst_pc),
    .int_idx_read0_o    (idx_read0),
    .int_idx_read1_o    (idx_read1),
    .dec_valid_o        (dec_valid),
    .dec_ready_i        (dec_ready),
    .dec_op_o           (dec_op),
    .dec_idx_write_o    (dec_idx_write),
    .dec_write_enable_o (dec_we),
    .dec_imm_o          (dec_imm),
    .dec_pc_o           (dec_pc),
    .dec_illegal_o      (dec_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        bank;
    logic [3:0]  op;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [4:0]  wr;
    logic        we;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;

    vecs[0]  = '{16'h6213, 1'b0, 4'd1,  5'd1,  5'd0,  5'd2,  1'b1, 32'h0,        1'b0};
    vecs[1]  = '{16'h33CC, 1'b1, 4'd3,  5'd19, 5'd12, 5'd19, 1'b1, 32'h0,        1'b0};
    vecs[2]  = '{16'h75FF, 1'b0, 4'd4,  5'd5,  5'd0,  5'd5,  1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{16'hE47F, 1'b0, 4'd2,  5'd0,  5'd0,  5'd4,  1'b1, 32'h0000007F, 1'b0};
    vecs[4]  = '{16'hFFFF, 1'b0, 4'd15, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,        1'b1};
    vecs[5]  = '{16'h0009, 1'b1, 4'd0,  5'd0,  5'd0,  5'd0,  1'b0, 32'h0,        1'b0};
    vecs[6]  = '{16'h3128, 1'b0, 4'd5,  5'd1,  5'd2,  5'd1,  1'b1, 32'h0,        1'b0};
    vecs[7]  = '{16'h2A39, 1'b1, 4'd6,  5'd10, 5'd19, 5'd10, 1'b1, 32'h0,        1'b0};
    vecs[8]  = '{16'h207B, 1'b1, 4'd7,  5'd16, 5'd23, 5'd16, 1'b1, 32'h0,        1'b0};
    vecs[9]  = '{16'h2F8A, 1'b0, 4'd8,  5'd15, 5'd8,  5'd15, 1'b1, 32'h0,        1'b0};
    vecs[10] = '{16'h6213, 1'b1, 4'd1,  5'd17, 5'd0,  5'd18, 1'b1, 32'h0,        1'b0};
    vecs[11] = '{16'h0019, 1'b0, 4'd15, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,        1'b1};
    vecs[12] = '{16'h6214, 1'b0, 4'd15, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,        1'b1};
    vecs[13] = '{16'h7080, 1'b1, 4'd4,  5'd16, 5'd0,  5'd16, 1'b1, 32'hFFFFFF80, 1'b0};

    reset       = 1'b1;
    bank_select = 1'b0;
    flush       = 1'b0;
    inst_valid  = 1'b0;
    inst_data   = 16'h0;
    inst_pc     = 32'h0;
    dec_ready   = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_op", {28'd0, dec_op}, 32'd0);
    chk("rst_we", {31'd0, dec_we}, 32'd0);
    chk("rst_ill", {31'd0, dec_illegal}, 32'd0);
    chk("rst_wr", {27'd0, dec_idx_write}, 32'd0);
    chk("rst_imm", dec_imm, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_rd0", {27'd0, idx_read0}, 32'd0);
    chk("rst_rd1", {27'd0, idx_read1}, 32'd0);
    chk("rst_inst_ready", {31'd0, inst_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven decode vectors
    dec_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      inst_valid  = 1'b1;
      inst_data   = vecs[i].data;
      bank_select = vecs[i].bank;
      inst_pc     = 32'h1000 + 32'(2 * i);
      #1;
      chk($sformatf("v%0d_inst_ready", i), {31'd0, inst_ready}, 32'd1);
      chk($sformatf("v%0d_acc_rd0", i), {27'd0, idx_read0}, {27'd0, vecs[i].rd0});
      chk($sformatf("v%0d_acc_rd1", i), {27'd0, idx_read1}, {27'd0, vecs[i].rd1});
      @(posedge clk); #1;
      inst_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, dec_valid}, 32'd1);
      chk($sformatf("v%0d_op", i), {28'd0, dec_op}, {28'd0, vecs[i].op});
      chk($sformatf("v%0d_wr", i), {27'd0, dec_idx_write}, {27'd0, vecs[i].wr});
      chk($sformatf("v%0d_we", i), {31'd0, dec_we}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d_imm", i), dec_imm, vecs[i].imm);
      chk($sformatf("v%0d_ill", i), {31'd0, dec_illegal}, {31'd0, vecs[i].ill});
      chk($sformatf("v%0d_pc", i), dec_pc, 32'h1000 + 32'(2 * i));
      chk($sformatf("v%0d_held_rd0", i), {27'd0, idx_read0}, {27'd0, vecs[i].rd0});
      chk($sformatf("v%0d_held_rd1", i), {27'd0, idx_read1}, {27'd0, vecs[i].rd1});
    end

    // Stall: hold ADD R12,R3 (bank 1) while MOV waits, bank flips mid-stall
    @(posedge clk); #1;
    dec_ready   = 1'b1;
    inst_valid  = 1'b1;
    inst_data   = 16'h33CC;
    bank_select = 1'b1;
    inst_pc     = 32'h100;
    @(posedge clk); #1;
    dec_ready   = 1'b0;
    inst_data   = 16'h6213;
    bank_select = 1'b0;
    inst_pc     = 32'h102;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_inst_ready", c), {31'd0, inst_ready}, 32'd0);
      chk($sformatf("stall%0d_rd0", c), {27'd0, idx_read0}, 32'd19);
      chk($sformatf("stall%0d_rd1", c), {27'd0, idx_read1}, 32'd12);
      bank_select = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", c), {31'd0, dec_valid}, 32'd1);
      chk($sformatf("stall%0d_op", c), {28'd0, dec_op}, 32'd3);
      chk($sformatf("stall%0d_wr", c), {27'd0, dec_idx_write}, 32'd19);
      chk($sformatf("stall%0d_pc", c), dec_pc, 32'h100);
    end
    dec_ready = 1'b1;
    #1;
    chk("release_inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("release_rd0", {27'd0, idx_read0}, 32'd17);
    chk("release_rd1", {27'd0, idx_read1}, 32'd0);
    @(posedge clk); #1;
    chk("release_valid", {31'd0, dec_valid}, 32'd1);
    chk("release_op", {28'd0, dec_op}, 32'd1);
    chk("release_wr", {27'd0, dec_idx_write}, 32'd18);
    chk("release_pc", dec_pc, 32'h102);

    // Illegal, then flush with a pending offer
    inst_data   = 16'hFFFF;
    bank_select = 1'b0;
    inst_pc     = 32'h300;
    @(posedge clk); #1;
    chk("ill_op", {28'd0, dec_op}, 32'd15);
    chk("ill_flag", {31'd0, dec_illegal}, 32'd1);
    chk("ill_we", {31'd0, dec_we}, 32'd0);
    dec_ready = 1'b0;
    flush     = 1'b1;
    inst_data = 16'h6213;
    inst_pc   = 32'h302;
    #1;
    chk("flush_inst_ready", {31'd0, inst_ready}, 32'd0);
    chk("flush_rd0", {27'd0, idx_read0}, 32'd0);
    @(posedge clk); #1;
    chk("flush_valid", {31'd0, dec_valid}, 32'd0);
    chk("flush_op_held", {28'd0, dec_op}, 32'd15);
    chk("flush_pc_held", dec_pc, 32'h300);
    flush      = 1'b0;
    inst_valid = 1'b0;
    #1;
    chk("post_flush_inst_ready", {31'd0, inst_ready}, 32'd1);
    @(posedge clk); #1;

    // NOP stream at full rate, then async reset mid-stream
    dec_ready  = 1'b1;
    inst_valid = 1'b1;
    inst_data  = 16'h0009;
    for (int k = 0; k < 5; k++) begin
      inst_pc = 32'h400 + 32'(2 * k);
      @(posedge clk); #1;
      chk($sformatf("stream%0d_valid", k), {31'd0, dec_valid}, 32'd1);
      chk($sformatf("stream%0d_pc", k), dec_pc, 32'h400 + 32'(2 * k));
      chk($sformatf("stream%0d_op", k), {28'd0, dec_op}, 32'd0);
    end
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("async_rst_pc", dec_pc, 32'd0);
    chk("async_rst_inst_ready", {31'd0, inst_ready}, 32'd1);
    inst_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("after_rst_valid", {31'd0, dec_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sh4a_decode.md
# sh4a_decode

Instruction decode stage for the SH-4A integer pipeline, directly upstream of the integer register file. It accepts 16-bit instruction words from fetch over a valid/ready handshake and decodes a fixed integer-ALU subset. It maps architectural Rm/Rn to 5-bit physical register indices using the current bank select, and drives the register file read indices. The decoded op is held in a single-entry output register, and the one-cycle registered read data from the register file lines up with `dec_valid`.

## Interface
- `RESET_OPCODE`, default 4'd0: value of `dec_op` after reset (NOP).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bank_select`  in  1  SR.MD&SR.RB; 1 maps R0–R7 to bank 1; sampled at accept.
- `flush`  in  1  synchronous; discards the held decoded instruction.
- `inst_valid`  in  1  fetch offers `inst_data`/`inst_pc`.
- `inst_ready`  out  1  decode can accept this cycle.
- `inst_data`  in  16  SH-4 instruction word.
- `inst_pc`  in  32  address of `inst_data`.
- `int_idx_read0`  out  5  register file read index 0.
- `int_idx_read1`  out  5  register file read index 1.
- `dec_valid`  out  1  decoded instruction held.
- `dec_ready`  in  1  downstream consumes when `dec_valid&&dec_ready`.
- `dec_op`  out  4  NOP=0, MOV=1, MOVI=2, ADD=3, ADDI=4, SUB=5, AND=6, OR=7, XOR=8, ILLEGAL=15.
- `dec_idx_write`  out  5  physical destination index.
- `dec_write_enable`  out  1  op writes `dec_idx_write`.
- `dec_imm`  out  32  sign-extended imm8.
- `dec_pc`  out  32  PC of held instruction.
- `dec_illegal`  out  1  held instruction is outside the subset.

## Operation
- Physical mapping for Rx (x=0..15): x<8 gives `{bank_select,1'b0,x[2:0]}`, which is 0–7 or 16–23. x≥8 gives x. The result is always ≤23.
- Decode by bit pattern, n=[11:8], m=[7:4]:
  - `0x0009`: NOP, no write.
  - `0110nnnnmmmm0011`: MOV, read0=Rm, write Rn.
  - `1110nnnniiiiiiii`: MOVI, write Rn, imm=sext(i).
  - `0111nnnniiiiiiii`: ADDI, read0=Rn, write Rn, imm=sext(i).
  - `0011nnnnmmmm1100`: ADD; `0011nnnnmmmm1000`: SUB; `0010nnnnmmmm1001`: AND; `0010nnnnmmmm1011`: OR; `0010nnnnmmmm1010`: XOR. For all five, read0=Rn, read1=Rm, write Rn.
  - Anything else: ILLEGAL, `dec_illegal`=1, `dec_write_enable`=0.
- Unused read ports, immediates and write indices decode to 0.
- `inst_ready = !flush && (!dec_valid || dec_ready)`. Accept = `inst_valid && inst_ready`.
- On accept, the output register loads all `dec_*` fields and the decoded read indices, and `dec_valid` is set to 1.
- If the held instruction is consumed and there is no accept, `dec_valid` goes to 0 and the fields hold.
- `flush` takes priority: `dec_valid` goes to 0 next edge and nothing is accepted that cycle.
- Read index drive is combinational. In an accept cycle, `int_idx_read0/1` carry the indices decoded from `inst_data`. Otherwise they carry the held indices.
- Because of that drive, register file read data always corresponds to the held instruction, including during stalls. RAW hazards against older instructions are resolved downstream.
- Reset (asynchronous) sets:
  - `dec_valid`=0, `dec_op`=RESET_OPCODE, `dec_illegal`=0, `dec_write_enable`=0.
  - `dec_idx_write`=0, `dec_imm`=0, `dec_pc`=0.
  - Held read indices=0, so `int_idx_read0/1`=0 unless an accept is in progress. `inst_ready`=1 when `flush`=0.

## Timing
- Latency: instruction accepted at edge N gives `dec_valid`=1 after edge N. Register file read data is valid in the same cycle (read indices were presented in cycle N-1→N).
- Throughput is one instruction per cycle when `dec_ready`=1 continuously.
- Simultaneous consume and accept: the new instruction replaces the old one with no bubble, and `dec_valid` stays 1.
- Stall (`dec_valid`=1, `dec_ready`=0): all outputs stable, `inst_ready`=0, read indices stable.
- `bank_select` changes during a stall do not alter held indices. They affect only the next accept.
- Reset asserted mid-stall clears state immediately. On the first edge after deassertion, `inst_ready`=1.

## Test plan
- Reset, then `inst_data`=0x6213 (MOV R1,R2), `bank_select`=0 → next cycle `dec_op`=1, `int_idx_read0`=1, `dec_idx_write`=2, `dec_write_enable`=1.
- `bank_select`=1, `inst_data`=0x33CC (ADD R12,R3) → `dec_op`=3, read0=19, read1=12, `dec_idx_write`=19.
- `inst_data`=0x75FF (ADDI #-1,R5), bank 0 → `dec_imm`=0xFFFF_FFFF, read0=5, write 5. Then 0xE47F (MOVI) → `dec_imm`=0x0000_007F, write 4.
- Hold `dec_ready`=0 for 3 cycles with `inst_valid`=1 → `inst_ready`=0, outputs and `int_idx_read*` frozen. Release → the next instruction loads on the same edge as the consume.
- `inst_data`=0xFFFF → `dec_op`=15, `dec_illegal`=1, `dec_write_enable`=0. Assert `flush` with `inst_valid`=1 → `dec_valid`=0 next cycle, no accept.
- Stream 0x0009 with `dec_ready`=1 → `dec_valid` stays 1 every cycle, `dec_pc` follows `inst_pc`. Assert `reset` asynchronously mid-stream → `dec_valid`=0 without a clock edge.
